axi4l_csr_subordinate: RTL and testbench

AXI4-Lite subordinate that terminates the manager side of the team's AXI4-Lite interface and exposes a bank of read/write control/status registers to the surrounding logic. It accepts write address and write data independently, applies byte strobes, returns OKAY or SLVERR responses, and serves single-cycle-latency reads. It sits behind an interconnect port as the register front-end of a peripheral.

---
 rtl/axi4l_csr_subordinate.sv | 155 +++++++++++++++
 tb/tb_axi4l_csr_subordinate.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_csr_subordinate.sv
// AXI4-Lite register-bank subordinate: independent AW/W holding slots, byte-strobed
// register lanes, single-cycle reads, OKAY/SLVERR on address range.

module axi4l_csr_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module axi4l_csr_subordinate #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (OFF_W + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  logic                                  aw_full, w_full, commit;
  logic [ADDR_WIDTH-1:0]                 aw_addr;
  logic [DATA_WIDTH-1:0]                 w_data;
  logic [STRB_W-1:0]                     w_strb;
  logic                                  wr_in_range;
  logic [IDX_W-1:0]                      wr_idx;
  logic [NUM_REGS-1:0]                   lane_we;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs;
  logic                                  unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  assign AWREADY     = !aw_full;
  assign WREADY      = !w_full;
  assign ARREADY     = !RVALID || RREADY;
  assign commit      = aw_full && w_full && (!BVALID || BREADY);
  assign wr_in_range = in_range(aw_addr);
  assign wr_idx      = idx_of(aw_addr);
  assign regs_o      = regs;

  // AW and W slots fill independently; both drain together on commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) aw_full <= 1'b0;
      else if (AWVALID && AWREADY) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end
      if (commit) w_full <= 1'b0;
      else if (WVALID && WREADY) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      BVALID     <= 1'b0;
      BRESP      <= OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= lane_we & {NUM_REGS{|w_strb}};
      if (commit) begin
        BVALID <= 1'b1;
        BRESP  <= wr_in_range ? OKAY : SLVERR;
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lane
    assign lane_we[i] = commit && wr_in_range && (wr_idx == IDX_W'(i));
    axi4l_csr_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .clk   (ACLK),
      .rst   (ARESET),
      .we    (lane_we[i]),
      .wdata (w_data),
      .wstrb (w_strb),
      .q     (regs[i])
    );
  end

  // Reads sample the registers before any same-edge commit lands.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= OKAY;
    end else if (ARVALID && ARREADY) begin
      RVALID <= 1'b1;
      if (in_range(ARADDR)) begin
        RDATA <= regs[idx_of(ARADDR)];
        RRESP <= OKAY;
      end else begin
        RDATA <= '0;
        RRESP <= SLVERR;
      end
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4l_csr_subordinate.sv
// Bench for axi4l_csr_subordinate: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.

module tb_axi4l_csr_subordinate;
  localparam int AW = 32, DW = 32, NR = 16, SW = DW/8, TW = NR*DW;

  logic          ACLK = 1'b0, ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic [2:0]    AWPROT = '0, ARPROT = '0;
  logic          AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [DW-1:0] WDATA = '0;
  logic [SW-1:0] WSTRB = '0;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]    BRESP, RRESP;
  logic [DW-1:0] RDATA;
  logic [TW-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  always #5 ACLK = ~ACLK;

  axi4l_csr_subordinate #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  int pass_cnt = 0, chk_cnt = 0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Model: pending AW/W transactions as queues, register file as an array.
  logic [DW-1:0] m_regs [NR];
  logic [AW-1:0] aw_q [$];
  logic [DW-1:0] wd_q [$];
  logic [SW-1:0] ws_q [$];
  logic          m_bvalid, m_rvalid;
  logic [1:0]    m_bresp, m_rresp;
  logic [DW-1:0] m_rdata;
  logic [NR-1:0] m_pulse;

  function automatic bit in_rng(input logic [AW-1:0] a);
    return a < AW'(NR*SW);
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a / SW) % NR);
  endfunction

  function automatic logic [DW-1:0] rw(input int i);
    return regs_o[i*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    aw_q.delete(); wd_q.delete(); ws_q.delete();
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_pulse = 0;
  endtask

  task automatic compare_all();
    logic [TW-1:0] er;
    for (int i = 0; i < NR; i++) er[i*DW +: DW] = m_regs[i];
    chk("awready", AWREADY, aw_q.size() == 0);
    chk("wready",  WREADY,  wd_q.size() == 0);
    chk("arready", ARREADY, !m_rvalid || RREADY);
    chk("bvalid",  BVALID,  m_bvalid);
    chk("bresp",   BRESP,   m_bresp);
    chk("rvalid",  RVALID,  m_rvalid);
    chk("rdata",   RDATA,   m_rdata);
    chk("rresp",   RRESP,   m_rresp);
    chk("regs",    regs_o,  er);
    chk("pulse",   wr_pulse_o, m_pulse);
  endtask

  // One clock: compare at negedge, advance model on posedge, drop accepted VALIDs.
  task automatic cyc();
    bit hs_aw, hs_w, hs_ar, commit;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int k;
    #4;
    compare_all();
    hs_aw  = AWVALID && aw_q.size() == 0;
    hs_w   = WVALID && wd_q.size() == 0;
    hs_ar  = ARVALID && (!m_rvalid || RREADY);
    commit = aw_q.size() > 0 && wd_q.size() > 0 && (!m_bvalid || BREADY);
    @(posedge ACLK);
    if (ARESET) model_reset();
    else begin
      if (hs_ar) begin
        m_rvalid = 1;
        m_rdata  = in_rng(ARADDR) ? m_regs[idx_of(ARADDR)] : '0;
        m_rresp  = in_rng(ARADDR) ? 2'b00 : 2'b10;
      end else if (RREADY) m_rvalid = 0;
      m_pulse = '0;
      if (commit) begin
        a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
        if (in_rng(a)) begin
          k = idx_of(a);
          for (int b = 0; b < SW; b++) if (s[b]) m_regs[k][8*b +: 8] = d[8*b +: 8];
          if (s != 0) m_pulse[k] = 1'b1;
        end
        m_bvalid = 1;
        m_bresp  = in_rng(a) ? 2'b00 : 2'b10;
      end else if (BREADY) m_bvalid = 0;
      if (hs_aw) aw_q.push_back(AWADDR);
      if (hs_w) begin wd_q.push_back(WDATA); ws_q.push_back(WSTRB); end
    end
    #1;
    if (hs_aw) AWVALID = 0;
    if (hs_w)  WVALID  = 0;
    if (hs_ar) ARVALID = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    repeat (3) cyc();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return $urandom | 32'h40;
      1:       return 32'h40 + AW'($urandom_range(0, 3));
      default: return AW'($urandom_range(0, NR*SW - 1));
    endcase
  endfunction

  initial begin
    model_reset();
    #3;
    compare_all();
    chk("rst_awready", AWREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_regs", regs_o, '0);
    @(posedge ACLK); #1;
    ARESET = 0;

    // Basic write, AW and W together, then read back.
    AWADDR = 32'h08; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    cyc();
    chk("t1_no_b_before_commit", BVALID, 0);
    cyc();
    chk("t1_bvalid", BVALID, 1);
    chk("t1_bresp", BRESP, 2'b00);
    chk("t1_reg2", rw(2), 32'hDEADBEEF);
    chk("t1_pulse", wr_pulse_o, 16'h0004);
    cyc();
    chk("t1_pulse_gone", wr_pulse_o, 0);
    ARADDR = 32'h08; ARVALID = 1; RREADY = 1;
    cyc();
    chk("t1_rvalid", RVALID, 1);
    chk("t1_rdata", RDATA, 32'hDEADBEEF);
    chk("t1_rresp", RRESP, 2'b00);
    cyc();

    // W three cycles before AW, then the reverse; partial strobes.
    wr(32'h04, 32'h11223344, 4'hF);
    WDATA = 32'h0000AB00; WSTRB = 4'h2; WVALID = 1;
    repeat (3) begin cyc(); chk("t2_w_only_no_b", BVALID, 0); end
    AWADDR = 32'h04; AWVALID = 1;
    cyc();
    chk("t2_no_b_yet", BVALID, 0);
    cyc();
    chk("t2_bvalid", BVALID, 1);
    chk("t2_reg1", rw(1), 32'h1122AB44);
    cyc();
    AWADDR = 32'h04; AWVALID = 1;
    cyc();
    repeat (2) begin cyc(); chk("t2_aw_only_no_b", BVALID, 0); end
    WDATA = 32'h00CD0000; WSTRB = 4'h4; WVALID = 1;
    cyc();
    chk("t2r_no_b_yet", BVALID, 0);
    cyc();
    chk("t2r_bvalid", BVALID, 1);
    chk("t2r_reg1", rw(1), 32'h11CDAB44);
    cyc();

    // Out-of-range write and read.
    AWADDR = 32'h40; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    cyc(); cyc();
    chk("t3_bresp", BRESP, 2'b10);
    chk("t3_pulse", wr_pulse_o, 0);
    chk("t3_reg0", rw(0), 0);
    cyc();
    ARADDR = 32'h40; ARVALID = 1; RREADY = 1;
    cyc();
    chk("t3_rresp", RRESP, 2'b10);
    chk("t3_rdata", RDATA, 0);
    cyc();

    // B back-pressure with a second write queued behind it.
    BREADY = 0;
    AWADDR = 32'h14; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    cyc(); cyc();
    chk("t4_b1", BVALID, 1);
    AWADDR = 32'h18; WDATA = 32'h5A5A5A5A; AWVALID = 1; WVALID = 1;
    cyc();
    chk("t4_aw2_accepted", AWREADY, 0);
    repeat (4) begin
      cyc();
      chk("t4_b1_held", BVALID, 1);
      chk("t4_bresp_held", BRESP, 2'b00);
      chk("t4_reg6_unchanged", rw(6), 0);
    end
    BREADY = 1;
    cyc();
    chk("t4_b2", BVALID, 1);
    chk("t4_reg6", rw(6), 32'h5A5A5A5A);
    chk("t4_pulse", wr_pulse_o, 16'h0040);
    cyc();
    chk("t4_b_done", BVALID, 0);

    // Read and commit hitting reg3 on the same edge.
    wr(32'h0C, 32'h1, 4'hF);
    AWADDR = 32'h0C; WDATA = 32'h2; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    cyc();
    ARADDR = 32'h0C; ARVALID = 1; RREADY = 1;
    cyc();
    chk("t5_rdata_old", RDATA, 32'h1);
    chk("t5_reg3_new", rw(3), 32'h2);
    ARVALID = 1;
    cyc();
    chk("t5_rdata_new", RDATA, 32'h2);
    cyc();

    // Asynchronous reset mid-transaction.
    AWADDR = 32'h10; AWVALID = 1; ARADDR = 32'h08; ARVALID = 1; RREADY = 0; BREADY = 1;
    cyc();
    chk("t6_rvalid_pre", RVALID, 1);
    chk("t6_aw_held_pre", AWREADY, 0);
    #1;
    ARESET = 1; AWVALID = 0; WVALID = 0; ARVALID = 0;
    #1;
    model_reset();
    compare_all();
    chk("t6_rst_regs", regs_o, '0);
    chk("t6_rst_rvalid", RVALID, 0);
    chk("t6_rst_rdata", RDATA, 0);
    chk("t6_rst_awready", AWREADY, 1);
    @(posedge ACLK); #1;
    ARESET = 0;
    WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1;
    repeat (3) begin cyc(); chk("t6_w_alone_no_b", BVALID, 0); end
    chk("t6_reg4", rw(4), 0);

    // Randomized traffic.
    repeat (3000) begin
      if (!AWVALID && $urandom_range(0, 2) == 0) begin AWADDR = rnd_addr(); AWVALID = 1; end
      if (!WVALID && $urandom_range(0, 2) == 0) begin
        WDATA = $urandom; WSTRB = SW'($urandom_range(0, 15)); WVALID = 1;
      end
      if (!ARVALID && $urandom_range(0, 1) == 0) begin ARADDR = rnd_addr(); ARVALID = 1; end
      BREADY = $urandom_range(0, 3) != 0;
      RREADY = $urandom_range(0, 3) != 0;
      cyc();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
